// File: rtl/frame_pkg.sv
// frame_pkg: header bytes, framer state encoding and frame length for adc_frame_tx.
// Defining FRAME_CKSUM_EN adds the trailing XOR checksum byte to every frame.
package frame_pkg;
   localparam logic [7:0] HDR_MARK = 8'hFF;
   localparam logic [7:0] HDR_PAD = 8'h00;
   localparam int HDR_LEN = 4;
`ifdef FRAME_CKSUM_EN
   localparam bit CKSUM_EN = 1'b1;
`else
   localparam bit CKSUM_EN = 1'b0;
`endif
   typedef enum logic {IDLE, SEND} state_t;
   function automatic int frame_len(input int num_ch);
      return HDR_LEN + 2 * num_ch + (CKSUM_EN ? 1 : 0);
   endfunction
   // Header reads FF 00 00 FF.
   function automatic logic [7:0] hdr_byte(input logic [1:0] n);
      return (n == 2'd0 || n == 2'd3) ? HDR_MARK : HDR_PAD;
   endfunction
endpackage

// File: rtl/period_timer.sv
// period_timer: free-running 0..PERIOD_CYC-1 counter, held at 0 while disabled,
// with a tick on the terminal count.
module period_timer
   import frame_pkg::*;
#(
   parameter int PERIOD_CYC = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int W = $clog2(PERIOD_CYC);
   localparam logic [W-1:0] LAST = W'(PERIOD_CYC - 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (en && cnt != LAST) ? cnt + 1'b1 : '0;
   assign tick = en && cnt == LAST;
endmodule

// File: rtl/adc_frame_tx.sv
// adc_frame_tx: snapshots ADC channels on a trigger and streams a header+sample frame
// over a valid/ready byte interface; FRAME_CKSUM_EN appends an XOR checksum byte.
module adc_frame_tx
   import frame_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 12,
   parameter int PERIOD_CYC = 100000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     trig,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     overrun
);
   localparam logic [4:0] LAST = 5'(frame_len(NUM_CH) - 1);
   localparam logic [4:0] CH_END = 5'(HDR_LEN + 2 * NUM_CH);
   state_t state;
   logic pending, tick, trigger, xfer;
   logic [4:0] idx, nxt;
   logic [3:0] off;
   logic [NUM_CH*DATA_W-1:0] snap;
   logic [15:0] ch16 [8];
   logic [7:0] cksum, nxt_byte;
   period_timer #(.PERIOD_CYC(PERIOD_CYC)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );
   assign trigger = en && (tick || trig);
   assign xfer = tx_valid && tx_ready;
   assign busy = state == SEND;
   // Byte following the one on the bus, chosen from the snapshot only.
   always_comb begin
      ch16 = '{default: '0};
      cksum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch16[i] = 16'(snap[i*DATA_W +: DATA_W]);
         cksum = cksum ^ ch16[i][15:8] ^ ch16[i][7:0];
      end
      nxt = idx + 5'd1;
      off = 4'(nxt - 5'(HDR_LEN));
      nxt_byte = nxt < 5'(HDR_LEN) ? hdr_byte(nxt[1:0]) :
                 nxt < CH_END ? (off[0] ? ch16[off[3:1]][7:0] : ch16[off[3:1]][15:8]) : cksum;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         pending <= 1'b0;
         idx <= '0;
         snap <= '0;
         tx_valid <= 1'b0;
         tx_data <= '0;
         frame_done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         overrun <= 1'b0;
         if (state == IDLE) begin
            pending <= 1'b0;
            if (trigger || (pending && en)) begin
               state <= SEND;
               snap <= ch_data;
               idx <= '0;
               tx_valid <= 1'b1;
               tx_data <= HDR_MARK;
            end
         end else begin
            // One frame may queue behind the current one; a second is dropped.
            if (!en) pending <= 1'b0;
            else if (trigger) begin
               pending <= 1'b1;
               overrun <= pending;
            end
            if (xfer) begin
               if (idx == LAST) begin
                  state <= IDLE;
                  tx_valid <= 1'b0;
                  frame_done <= 1'b1;
               end else begin
                  idx <= nxt;
                  tx_data <= nxt_byte;
               end
            end
         end
      end
endmodule

// File: doc/adc_frame_tx.md
ADC_FRAME_TX -- requirements
Module: adc_frame_tx

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of ADC channels per frame (1..8).
REQ-002 SHALL have parameter DATA_W, default 12, bits per channel sample (1..16).
REQ-003 SHALL have parameter PERIOD_CYC, default 100000000, clk cycles between periodic triggers (>= 64).
REQ-004 SHALL have port clk, input, 1, single system clock, 100 MHz.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port en, input, 1, enables periodic and manual triggering.
REQ-007 SHALL have port trig, input, 1, single-cycle manual frame request.
REQ-008 SHALL have port ch_data, input, NUM_CH*DATA_W, channel samples, ch0 in the LSBs.
REQ-009 SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-010 SHALL have port tx_valid, output, 1, tx_data is valid.
REQ-011 SHALL have port tx_ready, input, 1, transmitter accepts the byte.
REQ-012 SHALL have port busy, output, 1, high while a frame is being sent.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse after the last byte is accepted.
REQ-014 SHALL have port overrun, output, 1, one-cycle pulse when a trigger is dropped.

Function
REQ-015 Frame byte order SHALL be: header FF 00 00 FF; then per channel ch0 first, {zero-extend ch[DATA_W-1:8]}, then ch[7:0]; then an optional checksum byte (REQ-030). Length L = 4+2*NUM_CH (+1 with checksum).
REQ-016 For DATA_W <= 8, the high byte of each channel SHALL be 00.
REQ-017 The period counter SHALL count 0..PERIOD_CYC-1 while en=1, wrap to 0, and raise a trigger on the PERIOD_CYC-1 cycle; it SHALL be held at 0 while en=0.
REQ-018 A trigger is a periodic tick or trig=1; both are ignored while en=0, and a tick and trig in the same cycle SHALL count as one trigger.
REQ-019 States SHALL be IDLE and SEND. IDLE->SEND on a trigger or pending=1. SEND->IDLE on acceptance of byte L-1.
REQ-020 On the IDLE->SEND edge, all of ch_data SHALL be snapshotted, and tx_valid=1 with tx_data=FF SHALL be visible from the next cycle (one-cycle latency).
REQ-021 A byte SHALL transfer on a cycle with tx_valid && tx_ready; the next byte SHALL be presented on the following cycle with no bubble.
REQ-022 tx_data SHALL stay stable while tx_valid && !tx_ready, and tx_valid SHALL NOT drop until the transfer happens.
REQ-023 Changes on ch_data during SEND SHALL NOT affect the frame in flight.
REQ-024 A trigger during SEND SHALL set a one-deep pending flag; the pending frame SHALL start on the cycle after frame_done.
REQ-025 A trigger during SEND while pending=1 SHALL be dropped and SHALL pulse overrun for one cycle.
REQ-026 When en falls during SEND, the current frame SHALL complete, pending SHALL be cleared, and no further frame SHALL start.
REQ-027 busy SHALL equal (state==SEND); frame_done SHALL pulse one cycle after the transfer of the last byte.

Reset
REQ-028 On rst, the block SHALL immediately take: state IDLE, counter 0, pending 0, tx_valid 0, tx_data 00, busy 0, frame_done 0, overrun 0, snapshot 0.
REQ-029 Reset mid-frame SHALL abort the frame; the first frame after reset release SHALL begin with the header.

Configuration
REQ-030 With FRAME_CKSUM_EN defined, a checksum byte SHALL be appended: the XOR of all channel bytes (header excluded). Without it, no checksum SHALL be sent and L = 4+2*NUM_CH.

Structure
REQ-031 Package frame_pkg SHALL hold the header byte constants, the state encoding, and the frame-length function.
REQ-032 Sub-module period_timer SHALL implement the counter and tick of REQ-017; the framer FSM and byte mux SHALL stay in adc_frame_tx.

Verification (NUM_CH=2, DATA_W=12, PERIOD_CYC=100, FRAME_CKSUM_EN defined unless stated)
REQ-033 en=1, ch0=ABC, ch1=123, tx_ready=1 -> bytes FF 00 00 FF 0A BC 01 23 94 sent; frame_done one cycle after 94; next frame starts 100 cycles after the first.
REQ-034 tx_ready=0 for 5 cycles on byte 5 -> tx_data holds BC all 5 cycles; no byte is lost or duplicated.
REQ-035 trig during SEND -> second frame starts on the cycle after frame_done; a further trig while pending -> one overrun pulse and exactly two frames sent.
REQ-036 ch0 changes to 555 after byte 2 -> the frame carries 0A BC.
REQ-037 rst pulsed after byte 6 -> tx_valid=0 immediately; the next trigger sends a full frame starting FF 00 00 FF.
REQ-038 FRAME_CKSUM_EN undefined, en dropped after byte 3 -> 8-byte frame completes; no further output for 300 cycles.
